// File: rtl/sbqm_pkg.sv
// Shared constants and FSM encoding for the smart bank queue manager.
package sbqm_pkg;

  localparam int PCOUNT_W = 3;
  localparam int TCOUNT_W = 2;
  localparam int WTIME_W  = 5;

  // ROM returns this value when no teller is active
  localparam logic [WTIME_W-1:0]  WTIME_NO_TELLER = 5'd31;
  localparam logic [PCOUNT_W-1:0] PCOUNT_MAX      = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/sbqm_edge_detect.sv
// Rising-edge pulse generator for one photocell sensor.
// Optional feature macro: SENSOR_SYNC_EN adds a two-flop synchronizer ahead
// of the edge detector, delaying the pulse by two cycles.
module sbqm_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sensor,
  output logic rise
);

  logic sensed;
  logic sensed_prev;

`ifdef SENSOR_SYNC_EN
  logic sync1;
  logic sync2;

  // Two-flop synchronizer bringing the asynchronous photocell into clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sensor;
      sync2 <= sync1;
    end
  end

  assign sensed = sync2;
`else
  assign sensed = sensor;
`endif

  // History register so a held-high sensor produces only one pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sensed_prev <= 1'b0;
    else     sensed_prev <= sensed;
  end

  assign rise = sensed & ~sensed_prev;

endmodule

// File: rtl/sbqm_queue_ctrl.sv
// Queue controller: counts customers from entry/exit photocells, keeps
// full/empty flags and sequences the waiting-time ROM lookup.
// Optional feature macro: SENSOR_SYNC_EN (synchronizes both sensors).
module sbqm_queue_ctrl
  import sbqm_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                back_sensor,
  input  logic                front_sensor,
  input  logic [TCOUNT_W-1:0] Tcount,
  input  logic [WTIME_W-1:0]  Wtime,
  output logic                ROM_enable,
  output logic [PCOUNT_W-1:0] Pcount,
  output logic [TCOUNT_W-1:0] Tcount_q,
  output logic [WTIME_W-1:0]  Wtime_out,
  output logic                wtime_valid,
  output logic                full,
  output logic                empty
);

  logic                back_rise;
  logic                front_rise;
  logic [PCOUNT_W-1:0] pcount_next;
  logic                refresh;
  logic                start_req;
  state_t              state;
  state_t              state_next;
  logic                pending;

  sbqm_edge_detect u_back_edge (
    .clk    (clk),
    .rst    (rst),
    .sensor (back_sensor),
    .rise   (back_rise)
  );

  sbqm_edge_detect u_front_edge (
    .clk    (clk),
    .rst    (rst),
    .sensor (front_sensor),
    .rise   (front_rise)
  );

  // Next customer count: simultaneous entry and exit cancel, blocked rises are dropped
  always_comb begin
    pcount_next = Pcount;
    if (back_rise && front_rise) begin
      pcount_next = Pcount;
    end else if (back_rise && !full) begin
      pcount_next = Pcount + 1'b1;
    end else if (front_rise && !empty) begin
      pcount_next = Pcount - 1'b1;
    end
  end

  // A new lookup is needed whenever either half of the ROM address moves
  assign refresh   = (pcount_next != Pcount) || (Tcount != Tcount_q);
  assign start_req = (state == IDLE) && pending;

  // Count and flags update together so full/empty always agree with Pcount
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Pcount   <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      Tcount_q <= '0;
    end else begin
      Pcount   <= pcount_next;
      full     <= (pcount_next == PCOUNT_MAX);
      empty    <= (pcount_next == '0);
      Tcount_q <= Tcount;
    end
  end

  // Pending lookup flag; starts set so the first lookup happens after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            pending <= 1'b1;
    else if (start_req) pending <= 1'b0;
    else if (refresh)   pending <= 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state and ROM strobe
  always_comb begin
    state_next = state;
    ROM_enable = 1'b0;
    case (state)
      IDLE: if (pending) state_next = REQ;
      REQ: begin
        ROM_enable = 1'b1;
        state_next = WAIT;
      end
      WAIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture ROM data on the cycle after the strobe and flag the update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Wtime_out   <= '0;
      wtime_valid <= 1'b0;
    end else begin
      wtime_valid <= (state == WAIT);
      if (state == WAIT) Wtime_out <= Wtime;
    end
  end

endmodule

// File: tb/tb_sbqm_queue_ctrl.sv
// Randomized scoreboard bench for sbqm_queue_ctrl with a behavioural ROM.
// Honours SENSOR_SYNC_EN for the rise-to-count latency check.
module tb_sbqm_queue_ctrl;
  import sbqm_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                back_sensor = 1'b0;
  logic                front_sensor = 1'b0;
  logic [TCOUNT_W-1:0] Tcount = 2'd1;
  logic [WTIME_W-1:0]  Wtime = 5'd26;
  logic                ROM_enable;
  logic [PCOUNT_W-1:0] Pcount;
  logic [TCOUNT_W-1:0] Tcount_q;
  logic [WTIME_W-1:0]  Wtime_out;
  logic                wtime_valid;
  logic                full;
  logic                empty;

`ifdef SENSOR_SYNC_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 1;
`endif

  int checks = 0;
  int failures = 0;
  int rom_pulses = 0;
  int model_cnt = 0;
  int model_t = 1;
  logic [WTIME_W-1:0] sb[$];
  logic rom_hold = 1'b0;

  sbqm_queue_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .back_sensor  (back_sensor),
    .front_sensor (front_sensor),
    .Tcount       (Tcount),
    .Wtime        (Wtime),
    .ROM_enable   (ROM_enable),
    .Pcount       (Pcount),
    .Tcount_q     (Tcount_q),
    .Wtime_out    (Wtime_out),
    .wtime_valid  (wtime_valid),
    .full         (full),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  // Waiting-time table: about three minutes per customer ahead, shared over tellers
  function automatic logic [WTIME_W-1:0] romModel(input int p, input int t);
    if (t == 0) return WTIME_NO_TELLER;
    if (p == 0) return 5'd0;
    return WTIME_W'((3 * (p + t - 1)) / t);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ROM responder: data valid the cycle after the strobe, junk otherwise
  always @(negedge clk) begin
    if (ROM_enable) begin
      Wtime = romModel(int'(Pcount), int'(Tcount_q));
      rom_hold = 1'b1;
      rom_pulses++;
    end else if (rom_hold) begin
      rom_hold = 1'b0;
    end else begin
      Wtime = 5'd26;
    end
  end

  // Scoreboard monitor: every wtime_valid pulse consumes one expected result
  always @(negedge clk) begin
    if (wtime_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_wtime_valid", 1, 0);
      end else begin
        check("wtime_out", int'(Wtime_out), int'(sb.pop_front()));
      end
    end
  end

  task automatic checkOutput(input string tag);
    check({tag, "_pcount"}, int'(Pcount), model_cnt);
    check({tag, "_full"}, int'(full), int'(model_cnt == 7));
    check({tag, "_empty"}, int'(empty), int'(model_cnt == 0));
    check({tag, "_tcount_q"}, int'(Tcount_q), model_t);
    check({tag, "_rom_idle"}, int'(ROM_enable), 0);
  endtask

  // Model the effect of one sensor/teller event and queue the lookup it triggers
  task automatic modelEvent(input logic b, input logic f, input int t);
    int old_cnt = model_cnt;
    int old_t = model_t;
    if (b && f) model_cnt = model_cnt;
    else if (b && model_cnt < 7) model_cnt++;
    else if (f && model_cnt > 0) model_cnt--;
    model_t = t;
    if (model_cnt != old_cnt || model_t != old_t)
      sb.push_back(romModel(model_cnt, model_t));
  endtask

  task automatic applyStimulus(input logic b, input logic f, input int t);
    @(negedge clk);
    back_sensor = b;
    front_sensor = f;
    Tcount = TCOUNT_W'(t);
    modelEvent(b, f, t);
    repeat (3) @(negedge clk);
    back_sensor = 1'b0;
    front_sensor = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic waitRomEnable(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ROM_enable) begin
        seen = 1'b1;
        break;
      end
    end
    check("rom_enable_seen", int'(seen), 1);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    int lat;

    // Reset values while held in reset
    repeat (3) @(negedge clk);
    check("rst_pcount", int'(Pcount), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_rom_enable", int'(ROM_enable), 0);
    check("rst_wtime_out", int'(Wtime_out), 0);
    check("rst_wtime_valid", int'(wtime_valid), 0);

    // First lookup forced after reset release with one teller
    sb.push_back(romModel(0, 1));
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("first_lookup_pulses", rom_pulses, 1);
    checkOutput("after_reset");

    // Fill the queue with two tellers, then one blocked entry
    applyStimulus(1'b0, 1'b0, 2);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 2);
    checkOutput("full_queue");
    check("full_wtime", int'(Wtime_out), 12);
    lat = rom_pulses;
    applyStimulus(1'b1, 1'b0, 2);
    checkOutput("blocked_entry");
    check("blocked_no_lookup", rom_pulses, lat);

    // Drain to three, then simultaneous entry and exit
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 2);
    lat = rom_pulses;
    applyStimulus(1'b1, 1'b1, 2);
    checkOutput("both_rises");
    check("both_no_lookup", rom_pulses, lat);

    // Drain to empty, exit while empty, then drop tellers to zero
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 2);
    checkOutput("empty_exit");
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 0);
    check("no_teller_wtime", int'(Wtime_out), 31);
    applyStimulus(1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 0);
    checkOutput("no_teller_count");

    // Entry arriving during the WAIT cycle forces a second lookup
    @(negedge clk);
    Tcount = 2'd3;
    modelEvent(1'b0, 1'b0, 3);
    waitRomEnable(seen);
    @(negedge clk);
    back_sensor = 1'b1;
    modelEvent(1'b1, 1'b0, 3);
    repeat (3) @(negedge clk);
    back_sensor = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("wait_event");
    check("wait_event_final", int'(Wtime_out), 5);

    // Randomized mix of entries, exits, simultaneous rises and teller changes
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: applyStimulus(1'b1, 1'b0, model_t);
        1: applyStimulus(1'b0, 1'b1, model_t);
        2: applyStimulus(1'b1, 1'b1, model_t);
        default: applyStimulus(1'b0, 1'b0, int'($urandom_range(0, 3)));
      endcase
    end
    checkOutput("random");

    // Reset in the middle of a lookup
    @(negedge clk);
    Tcount = (model_t == 1) ? 2'd2 : 2'd1;
    modelEvent(1'b0, 1'b0, int'(Tcount));
    waitRomEnable(seen);
    rst = 1'b1;
    #1;
    check("midrst_rom_enable", int'(ROM_enable), 0);
    check("midrst_pcount", int'(Pcount), 0);
    check("midrst_empty", int'(empty), 1);
    check("midrst_wtime_out", int'(Wtime_out), 0);
    check("midrst_tcount_q", int'(Tcount_q), 0);
    sb.delete();
    model_cnt = 0;
    model_t = 0;
    Tcount = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sb.push_back(romModel(0, 0));
    repeat (10) @(negedge clk);
    checkOutput("after_midrst");
    check("midrst_reissue", int'(Wtime_out), 31);

    // Sensor rise to count latency
    @(negedge clk);
    back_sensor = 1'b1;
    modelEvent(1'b1, 1'b0, 0);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (Pcount != 3'd0) break;
    end
    check("rise_latency", lat, EXP_LAT);
    back_sensor = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("latency");

    repeat (10) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
